// File: rtl/dc_filter_pkg.sv
// Shared definitions for the DC-restoration filter.
//   dc_state_e   : control states of dc_restore (idle / running / flushing)
//   DefDataWidth : default signed sample width
//   DefANum      : default pole numerator (a = DefANum / 2^DefAShift, about 0.95)
//   DefAShift    : default coefficient denominator exponent
//   ProdGuard    : extra bits carried by the coefficient product
//   SumGuard     : extra bits carried by the three-term sum before reduction
package dc_filter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } dc_state_e;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefANum      = 973;
  localparam int unsigned DefAShift    = 10;

  // The product x * A_NUM needs up to 10 extra magnitude bits; one more
  // keeps the sign safe for any A_NUM below 2^10.
  localparam int unsigned ProdGuard = 11;
  // acc + x - p spans at most three full-scale terms.
  localparam int unsigned SumGuard  = 2;

endpackage : dc_filter_pkg

// File: rtl/dc_sat.sv
// Combinational reduce-to-width for a signed value.
// Build option: DC_RESTORE_SAT_EN
//   defined   : out-of-range inputs are clamped to the OutWidth signed range
//   undefined : inputs are truncated to the low OutWidth bits (two's-complement wrap)
// In both modes ovf_o flags that the input does not fit in OutWidth bits, i.e.
// clamping happened or truncation changed the value.
// Ports:
//   in_i  : signed input, InWidth bits
//   out_o : reduced signed output, OutWidth bits
//   ovf_o : input was out of range for OutWidth
module dc_sat #(
  parameter int unsigned InWidth  = 34,
  parameter int unsigned OutWidth = 32
) (
  input  logic signed [InWidth-1:0]  in_i,
  output logic signed [OutWidth-1:0] out_o,
  output logic                       ovf_o
);

  // The value fits iff every bit from the output sign bit upward equals the sign.
  logic [InWidth-OutWidth:0] top_bits;

  always_comb begin
    top_bits = in_i[InWidth-1:OutWidth-1];
    ovf_o    = !((&top_bits) || (~|top_bits));
  end

`ifdef DC_RESTORE_SAT_EN
  always_comb begin
    out_o = in_i[OutWidth-1:0];
    if (ovf_o) begin
      if (in_i[InWidth-1]) begin
        out_o = {1'b1, {(OutWidth-1){1'b0}}};
      end else begin
        out_o = {1'b0, {(OutWidth-1){1'b1}}};
      end
    end
  end
`else
  always_comb begin
    out_o = in_i[OutWidth-1:0];
  end
`endif

endmodule : dc_sat

// File: rtl/dc_restore.sv
// DC restoration (inverse DC-removal) filter with AXI-Stream style handshakes.
//   y(n) = y(n-1) + x(n) - a*x(n-1),  a = A_NUM / 2^A_SHIFT
// One sample per input handshake, one cycle latency, full throughput while the
// output is ready. a*x(n-1) is floor((x(n-1)*A_NUM) / 2^A_SHIFT).
// Build option: DC_RESTORE_SAT_EN selects saturation instead of wrap on the
// reduced sum (see dc_sat).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clear          : synchronous filter-state clear (waits for a stalled output)
//   s_axis_*       : input sample x (tvalid/tready/tdata)
//   m_axis_*       : output sample y (tvalid/tready/tdata)
//   ovf            : sticky out-of-range flag, cleared by rst or clear
//   sample_cnt     : number of output handshakes, wraps at 16 bits
module dc_restore
  import dc_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned A_NUM      = DefANum,
  parameter int unsigned A_SHIFT    = DefAShift
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  ovf,
  output logic [15:0]           sample_cnt
);

  localparam int unsigned ProdWidth = DATA_WIDTH + ProdGuard;
  localparam int unsigned SumWidth  = DATA_WIDTH + SumGuard;

  // State
  dc_state_e                    state_q;
  logic signed [DATA_WIDTH-1:0] x_q;
  logic signed [DATA_WIDTH-1:0] acc_q;
  logic signed [DATA_WIDTH-1:0] y_q;
  logic                         m_valid_q;
  logic                         ovf_q;
  logic [15:0]                  cnt_q;

  // Datapath
  logic signed [DATA_WIDTH-1:0] x_in;
  logic signed [ProdWidth-1:0]  x_ext;
  logic signed [ProdWidth-1:0]  a_coef;
  logic signed [ProdWidth-1:0]  prod;
  logic signed [ProdWidth-1:0]  p;
  logic signed [SumWidth-1:0]   sum;
  logic signed [DATA_WIDTH-1:0] y_d;
  logic                         sum_ovf;

  // Control
  logic stalled;
  logic in_fire;
  logic out_fire;
  logic restart;

  always_comb begin
    x_in   = $signed(s_axis_tdata);
    x_ext  = {{ProdGuard{x_q[DATA_WIDTH-1]}}, x_q};
    a_coef = ProdWidth'(A_NUM);
    prod   = x_ext * a_coef;
    // Arithmetic shift of a signed value rounds toward minus infinity.
    p      = prod >>> A_SHIFT;
    sum    = {{SumGuard{acc_q[DATA_WIDTH-1]}}, acc_q}
           + {{SumGuard{x_in[DATA_WIDTH-1]}}, x_in}
           - p[SumWidth-1:0];
  end

  dc_sat #(
    .InWidth (SumWidth),
    .OutWidth(DATA_WIDTH)
  ) u_sat (
    .in_i (sum),
    .out_o(y_d),
    .ovf_o(sum_ovf)
  );

  always_comb begin
    stalled       = m_valid_q && !m_axis_tready;
    s_axis_tready = !rst && (state_q != StFlush) && !clear && !stalled;
    in_fire       = s_axis_tvalid && s_axis_tready;
    out_fire      = m_valid_q && m_axis_tready;
    // Return to a zeroed idle filter: a clear with nothing stalled, or the
    // moment the held output drains while flushing.
    if (state_q == StFlush) begin
      restart = out_fire;
    end else begin
      restart = clear && !stalled;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      m_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else if (restart) begin
      // The flushed sample is not counted; the counter is zeroed instead.
      state_q   <= StIdle;
      x_q       <= '0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        StIdle, StRun: begin
          if (clear) begin
            // Output is stalled: hold it until it is taken.
            state_q <= StFlush;
          end else begin
            if (out_fire) begin
              m_valid_q <= 1'b0;
              cnt_q     <= cnt_q + 16'd1;
            end
            if (in_fire) begin
              state_q   <= StRun;
              x_q       <= x_in;
              acc_q     <= y_d;
              y_q       <= y_d;
              m_valid_q <= 1'b1;
              ovf_q     <= ovf_q | sum_ovf;
            end
          end
        end
        StFlush: begin
          // Holding the pending output; restart handles its acceptance.
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = y_q;
  assign ovf           = ovf_q;
  assign sample_cnt    = cnt_q;

endmodule : dc_restore

// File: doc/dc_restore.md
DC_RESTORE -- requirements
Module: dc_restore

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: signed sample width.
REQ-002 SHALL have parameter A_NUM, default 973: pole coefficient numerator.
REQ-003 SHALL have parameter A_SHIFT, default 10: coefficient denominator exponent, so a = A_NUM/2^A_SHIFT (about 0.95).
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port clear  in  1  synchronous filter-state clear.
REQ-007 SHALL have ports s_axis_tvalid in 1, s_axis_tready out 1, s_axis_tdata in DATA_WIDTH: DC-removed input sample x.
REQ-008 SHALL have ports m_axis_tvalid out 1, m_axis_tready in 1, m_axis_tdata out DATA_WIDTH: restored output sample y.
REQ-009 SHALL have port ovf  out  1  sticky saturation/wrap flag.
REQ-010 SHALL have port sample_cnt  out  16  count of output handshakes.

Function
REQ-011 SHALL implement the inverse DC-removal filter y(n) = y(n-1) + x(n) - a*x(n-1) once per input handshake (tvalid and tready both high).
REQ-012 SHALL compute p = (x_q*A_NUM) >>> A_SHIFT as signed arithmetic at DATA_WIDTH+11 bits, rounding toward minus infinity, where x_q is the previous accepted x.
REQ-013 SHALL form sum = acc + x - p at DATA_WIDTH+2 bits, then reduce it to DATA_WIDTH bits per REQ-025.
REQ-014 SHALL, on each handshake, update x_q to x and acc to the reduced sum, and load the output register with the reduced sum.
REQ-015 SHALL present m_axis_tvalid one cycle after the input handshake (latency 1), and SHALL sustain throughput of 1 sample/cycle while m_axis_tready=1.
REQ-016 SHALL drive s_axis_tready = (state != FLUSH) and !clear and (!m_axis_tvalid or m_axis_tready).
REQ-017 SHALL keep m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-018 SHALL use a state machine with states IDLE (no sample since reset/clear, x_q=acc=0), RUN and FLUSH.
REQ-019 SHALL move IDLE->RUN on the first input handshake.
REQ-020 SHALL, on clear with no pending output (m_axis_tvalid=0 or m_axis_tready=1), zero x_q, acc, ovf and sample_cnt next cycle and go to IDLE.
REQ-021 SHALL, on clear while an output is stalled, go to FLUSH, hold that output until it is accepted, then zero state as in REQ-020 and go to IDLE.
REQ-022 SHALL give clear priority over a simultaneous input: no sample is accepted in a cycle with clear=1.
REQ-023 SHALL increment sample_cnt on each output handshake, wrapping 0xFFFF->0, and SHALL NOT count the flushed sample in FLUSH.

Reset
REQ-024 SHALL, on rst, set state=IDLE, x_q=0, acc=0, m_axis_tvalid=0, m_axis_tdata=0, ovf=0, sample_cnt=0 and s_axis_tready=0 during reset; rst overrides clear and all handshakes.

Configuration
REQ-025 SHALL, with macro DC_RESTORE_SAT_EN defined, clamp sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and set ovf when clamping occurs.
REQ-026 SHALL, without DC_RESTORE_SAT_EN, truncate sum to the low DATA_WIDTH bits (two's-complement wrap) and set ovf when truncation changes the value.

Structure
REQ-027 SHALL place the state enum (IDLE, RUN, FLUSH) and the default coefficient constants in a shared package dc_filter_pkg.
REQ-028 SHALL contain one sub-module, dc_sat, a parameterised combinational reduce-to-width with an overflow output, shared with REQ-025/026.

Verification
REQ-029 SHALL verify step response: x=1000 constant, m_axis_tready=1 -> y=1000, 1050, 1100, ... (+50/sample), ovf=0.
REQ-030 SHALL verify impulse response: x=1024, 0, 0, 0 -> y=1024, 51, 51, 51.
REQ-031 SHALL verify saturation: DATA_WIDTH=16, DC_RESTORE_SAT_EN, x=32767 repeated -> y=32767, 32767 (sum 34399 clamped), ovf=1 from the 2nd output.
REQ-032 SHALL verify backpressure: m_axis_tready=0 for 5 cycles with an output pending -> m_axis_tdata stable, s_axis_tready=0, no sample lost after release.
REQ-033 SHALL verify clear during stall: FLUSH holds the pending y until m_axis_tready=1 -> next input x=200 gives y=200 and sample_cnt=1.
REQ-034 SHALL verify clear plus simultaneous s_axis_tvalid: the sample is not accepted (s_axis_tready=0) -> state IDLE, acc=0.
